// File: rtl/game_controller.sv
// game_controller: serve/play/pause/point/game-over sequencing for a two-player ball game
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   tick                    ball-move strobe, sole time base for the serve/point delays
//   start, pause            level buttons, acted on at their rising edges
//   ball_center_col         ball centre column from the ball mover
//   ball_enable, ball_reset ball mover run enable and one-cycle re-centre pulse
//   serve_dir               initial ball direction, 1 = right
//   l_score, r_score        player scores
//   game_over, winner       end-of-game flag and winning side, 1 = right
//   state                   encoded FSM state for debug
module game_controller #(
    parameter int DISP_COLS   = 800,
    parameter int B_WIDTH     = 6,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60,
    parameter int POINT_DELAY = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic        pause,
    input  logic [11:0] ball_center_col,
    output logic        ball_enable,
    output logic        ball_reset,
    output logic        serve_dir,
    output logic [3:0]  l_score,
    output logic [3:0]  r_score,
    output logic        game_over,
    output logic        winner,
    output logic [2:0]  state
);
    localparam logic [2:0] IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, PAUSE = 3'd3, POINT = 3'd4, GAME_OVER = 3'd5;
    localparam int MAXD = (SERVE_DELAY > POINT_DELAY) ? SERVE_DELAY : POINT_DELAY;
    localparam int CW = $clog2(MAXD + 1);
    typedef logic [CW:0] cnt_ext_t;
    logic [2:0] next_state;
    logic [CW-1:0] cnt;
    logic start_q, pause_q, start_edge, pause_edge;
    logic l_miss, r_miss, serve_done, point_done, win;
    assign start_edge = start & ~start_q;
    assign pause_edge = pause & ~pause_q;
    assign l_miss = ball_center_col <= 12'(2 + B_WIDTH / 2);
    assign r_miss = ({1'b0, ball_center_col} + 13'(B_WIDTH / 2)) >= 13'(DISP_COLS - 2);
    // The current cycle's tick is included so the delay ends on the qualifying tick itself
    assign serve_done = (cnt_ext_t'(cnt) + cnt_ext_t'(tick)) >= cnt_ext_t'(SERVE_DELAY);
    assign point_done = (cnt_ext_t'(cnt) + cnt_ext_t'(tick)) >= cnt_ext_t'(POINT_DELAY);
    assign win = (l_score == 4'(WIN_SCORE)) || (r_score == 4'(WIN_SCORE));
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = start_edge ? SERVE : IDLE;
            SERVE:     next_state = serve_done ? PLAY : SERVE;
            PLAY:      next_state = (l_miss || r_miss) ? POINT : pause_edge ? PAUSE : PLAY;
            PAUSE:     next_state = pause_edge ? PLAY : PAUSE;
            POINT:     next_state = point_done ? (win ? GAME_OVER : SERVE) : POINT;
            GAME_OVER: next_state = start_edge ? SERVE : GAME_OVER;
            default:   next_state = IDLE;
        endcase
    end
    always_comb begin
        ball_enable = state == PLAY;
        game_over   = state == GAME_OVER;
        winner      = game_over && (r_score == 4'(WIN_SCORE));
    end
    // Button samplers follow the pins even during reset, so a button held
    // through reset reads as already pressed and yields no edge on release of reset.
    always_ff @(posedge clk) begin
        start_q <= start;
        pause_q <= pause;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            l_score    <= '0;
            r_score    <= '0;
            serve_dir  <= 1'b1;
            ball_reset <= 1'b0;
        end else begin
            ball_reset <= (next_state == SERVE) && (state != SERVE);
            // On any state change the counter restarts, keeping a coincident tick for the new state
            cnt <= (next_state != state) ? CW'(tick)
                 : (tick && (state == SERVE || state == POINT)) ? cnt + CW'(1) : cnt;
            if ((state == IDLE || state == GAME_OVER) && start_edge) begin
                l_score   <= '0;
                r_score   <= '0;
                serve_dir <= 1'b1;
            end else if (state == PLAY && l_miss) begin
                r_score   <= (r_score < 4'(WIN_SCORE)) ? r_score + 4'd1 : r_score;
                serve_dir <= 1'b0;
            end else if (state == PLAY && r_miss) begin
                l_score   <= (l_score < 4'(WIN_SCORE)) ? l_score + 4'd1 : l_score;
                serve_dir <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: scoreboard-driven check of the game_controller sequencing
module tb_game_controller;
    logic clk = 1'b0, reset = 1'b1, tick = 1'b0, start = 1'b0, pause = 1'b0;
    logic [11:0] ball_center_col = 12'd400;
    logic ball_enable, ball_reset, serve_dir, game_over, winner;
    logic [3:0] l_score, r_score;
    logic [2:0] state;
    logic [15:0] snap;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int n_cmp = 0, n_err = 0;

    game_controller #(.DISP_COLS(800), .B_WIDTH(6), .WIN_SCORE(2), .SERVE_DELAY(2), .POINT_DELAY(3)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause),
        .ball_center_col(ball_center_col), .ball_enable(ball_enable), .ball_reset(ball_reset),
        .serve_dir(serve_dir), .l_score(l_score), .r_score(r_score), .game_over(game_over),
        .winner(winner), .state(state)
    );

    always #5 clk = ~clk;
    assign snap = {state, ball_enable, ball_reset, serve_dir, l_score, r_score, game_over, winner};

    // Expected snapshot: state, ball_enable, ball_reset, serve_dir, l_score, r_score, game_over, winner
    function automatic logic [31:0] mk(int st, int en, int br, int dir, int l, int r, int go, int w);
        return 32'({3'(st), 1'(en), 1'(br), 1'(dir), 4'(l), 4'(r), 1'(go), 1'(w)});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick(int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        step();
        step();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL reset: got %h want %h", snap, e[15:0]); end
        reset = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        step();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL idle_hold: got %h want %h", snap, e[15:0]); end
    endtask

    task automatic test_serve();
        start = 1'b1;
        exp_q.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
        step();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL serve_entry: got %h want %h", snap, e[15:0]); end
        exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
        step();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL serve_pulse_end: got %h want %h", snap, e[15:0]); end
        exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
        pulse_tick(1);
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL serve_tick1: got %h want %h", snap, e[15:0]); end
        exp_q.push_back(mk(2, 1, 0, 1, 0, 0, 0, 0));
        pulse_tick(1);
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL play_entry: got %h want %h", snap, e[15:0]); end
        start = 1'b0;
        step();
        start = 1'b1;
        exp_q.push_back(mk(2, 1, 0, 1, 0, 0, 0, 0));
        step();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL play_start_ignored: got %h want %h", snap, e[15:0]); end
        start = 1'b0;
    endtask

    task automatic test_left_miss();
        ball_center_col = 12'd6;
        exp_q.push_back(mk(2, 1, 0, 1, 0, 0, 0, 0));
        step();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL left_boundary: got %h want %h", snap, e[15:0]); end
        ball_center_col = 12'd794;
        exp_q.push_back(mk(2, 1, 0, 1, 0, 0, 0, 0));
        step();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL right_boundary: got %h want %h", snap, e[15:0]); end
        ball_center_col = 12'd5;
        exp_q.push_back(mk(4, 0, 0, 0, 0, 1, 0, 0));
        step();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL left_miss: got %h want %h", snap, e[15:0]); end
        exp_q.push_back(mk(4, 0, 0, 0, 0, 1, 0, 0));
        step();
        ball_center_col = 12'd400;
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL point_single_score: got %h want %h", snap, e[15:0]); end
        exp_q.push_back(mk(4, 0, 0, 0, 0, 1, 0, 0));
        pulse_tick(2);
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL point_tick2: got %h want %h", snap, e[15:0]); end
        exp_q.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0));
        pulse_tick(1);
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL point_to_serve: got %h want %h", snap, e[15:0]); end
        exp_q.push_back(mk(2, 1, 0, 0, 0, 1, 0, 0));
        pulse_tick(2);
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL replay: got %h want %h", snap, e[15:0]); end
    endtask

    task automatic test_pause();
        pause = 1'b1;
        exp_q.push_back(mk(3, 0, 0, 0, 0, 1, 0, 0));
        step();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL pause_entry: got %h want %h", snap, e[15:0]); end
        pause = 1'b0;
        ball_center_col = 12'd5;
        start = 1'b1;
        exp_q.push_back(mk(3, 0, 0, 0, 0, 1, 0, 0));
        pulse_tick(5);
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL pause_hold: got %h want %h", snap, e[15:0]); end
        start = 1'b0;
        ball_center_col = 12'd400;
        pause = 1'b1;
        exp_q.push_back(mk(2, 1, 0, 0, 0, 1, 0, 0));
        step();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL resume: got %h want %h", snap, e[15:0]); end
        pause = 1'b0;
        step();
    endtask

    task automatic test_pause_miss();
        ball_center_col = 12'd795;
        pause = 1'b1;
        exp_q.push_back(mk(4, 0, 0, 1, 1, 1, 0, 0));
        step();
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL pause_vs_miss: got %h want %h", snap, e[15:0]); end
        pause = 1'b0;
        ball_center_col = 12'd400;
        exp_q.push_back(mk(1, 0, 1, 1, 1, 1, 0, 0));
        pulse_tick(3);
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL serve_again: got %h want %h", snap, e[15:0]); end
        exp_q.push_back(mk(2, 1, 0, 1, 1, 1, 0, 0));
        pulse_tick(2);
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL play_again: got %h want %h", snap, e[15:0]); end
    endtask

    task automatic test_game_over_left();
        ball_center_col = 12'd795;
        exp_q.push_back(mk(4, 0, 0, 1, 2, 1, 0, 0));
        step();
        ball_center_col = 12'd400;
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL l_score_two: got %h want %h", snap, e[15:0]); end
        exp_q.push_back(mk(5, 0, 0, 1, 2, 1, 1, 0));
        pulse_tick(3);
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL game_over_left: got %h want %h", snap, e[15:0]); end
        exp_q.push_back(mk(5, 0, 0, 1, 2, 1, 1, 0));
        pulse_tick(2);
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL game_over_hold: got %h want %h", snap, e[15:0]); end
        start = 1'b1;
        tick = 1'b1;
        exp_q.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
        step();
        tick = 1'b0;
        start = 1'b0;
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL restart: got %h want %h", snap, e[15:0]); end
        exp_q.push_back(mk(2, 1, 0, 1, 0, 0, 0, 0));
        pulse_tick(1);
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL tick_on_entry: got %h want %h", snap, e[15:0]); end
    endtask

    task automatic test_game_over_right();
        ball_center_col = 12'd5;
        exp_q.push_back(mk(4, 0, 0, 0, 0, 1, 0, 0));
        step();
        ball_center_col = 12'd400;
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL r_score_one: got %h want %h", snap, e[15:0]); end
        exp_q.push_back(mk(2, 1, 0, 0, 0, 1, 0, 0));
        pulse_tick(5);
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL back_to_back_rally: got %h want %h", snap, e[15:0]); end
        ball_center_col = 12'd5;
        exp_q.push_back(mk(4, 0, 0, 0, 0, 2, 0, 0));
        step();
        ball_center_col = 12'd400;
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL r_score_two: got %h want %h", snap, e[15:0]); end
        exp_q.push_back(mk(5, 0, 0, 0, 0, 2, 1, 1));
        pulse_tick(3);
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL game_over_right: got %h want %h", snap, e[15:0]); end
    endtask

    task automatic test_reset_mid_point();
        start = 1'b1;
        exp_q.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
        step();
        start = 1'b0;
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL restart_right: got %h want %h", snap, e[15:0]); end
        pulse_tick(2);
        ball_center_col = 12'd5;
        exp_q.push_back(mk(4, 0, 0, 0, 0, 1, 0, 0));
        step();
        ball_center_col = 12'd400;
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL point_before_reset: got %h want %h", snap, e[15:0]); end
        pulse_tick(1);
        start = 1'b1;
        reset = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        step();
        reset = 1'b0;
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL reset_mid_point: got %h want %h", snap, e[15:0]); end
        exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        pulse_tick(3);
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL held_start_no_edge: got %h want %h", snap, e[15:0]); end
        start = 1'b0;
        step();
        start = 1'b1;
        exp_q.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
        step();
        start = 1'b0;
        e = exp_q.pop_front(); n_cmp++;
        if (32'(snap) !== e) begin n_err++; $display("FAIL fresh_press: got %h want %h", snap, e[15:0]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_serve();
        test_left_miss();
        test_pause();
        test_pause_miss();
        test_game_over_left();
        test_game_over_right();
        test_reset_mid_point();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
